// File: rtl/game_button_conditioner.sv
// Button input stage: two-flop synchronizer, per-button debounce, press/release edge pulses
// and an auto-repeat pulse train while a button is held.
module game_button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER   = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam bit               RPT_EN    = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  logic             clr;
  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;
  logic [N_BTN-1:0] press_evt;
  logic [N_BTN-1:0] release_evt;
  logic [N_BTN-1:0] repeat_evt;
  logic             any_reg;

  // Dropping ena behaves exactly like reset for every register in the block.
  assign clr = !rst_n || !ena;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] tmr_reg;
      logic             level_reg;
      logic             press_reg;
      logic             release_reg;
      logic             rep_reg;
      logic             settle;
      logic             rep_fire;
      rpt_state_t       state_reg;

      assign settle          = (sync2_reg[gi] != level_reg) && (cnt_reg == DB_LAST);
      assign press_evt[gi]   = settle && sync2_reg[gi];
      assign release_evt[gi] = settle && !sync2_reg[gi];

      always_ff @(posedge clk) begin
        if (clr) begin
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          press_reg   <= press_evt[gi];
          release_reg <= release_evt[gi];
          if (sync2_reg[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (settle) begin
            level_reg <= sync2_reg[gi];
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + ONE;
          end
        end
      end

      // A release on the expiry edge suppresses that repeat pulse.
      assign rep_fire = !release_evt[gi] &&
                        (((state_reg == DELAY) && (tmr_reg == RPT_DELAY)) ||
                         ((state_reg == REPEAT) && (tmr_reg == RPT_PER)));
      assign repeat_evt[gi] = rep_fire;

      always_ff @(posedge clk) begin
        if (clr) begin
          state_reg <= IDLE;
          tmr_reg   <= '0;
          rep_reg   <= 1'b0;
        end else begin
          rep_reg <= rep_fire;
          case (state_reg)
            IDLE: begin
              if (press_evt[gi] && RPT_EN) begin
                state_reg <= DELAY;
                tmr_reg   <= ONE;
              end
            end
            DELAY: begin
              if (release_evt[gi]) begin
                state_reg <= IDLE;
                tmr_reg   <= '0;
              end else if (tmr_reg == RPT_DELAY) begin
                state_reg <= REPEAT;
                tmr_reg   <= ONE;
              end else begin
                tmr_reg <= tmr_reg + ONE;
              end
            end
            REPEAT: begin
              if (release_evt[gi]) begin
                state_reg <= IDLE;
                tmr_reg   <= '0;
              end else if (tmr_reg == RPT_PER) begin
                tmr_reg <= ONE;
              end else begin
                tmr_reg <= tmr_reg + ONE;
              end
            end
            default: begin
              state_reg <= IDLE;
              tmr_reg   <= '0;
            end
          endcase
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_repeat[gi]  = rep_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) any_reg <= 1'b0;
    else     any_reg <= |(press_evt | repeat_evt);
  end

  assign any_press = any_reg;

endmodule

// File: tb/tb_game_button_conditioner.sv
// Bench for game_button_conditioner: stimulus schedules expected edge/repeat events into a
// cycle-ordered queue; a negedge monitor pops them and compares every output each cycle.
module tb_game_button_conditioner;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_REP   = 2;
  localparam int K_CLR   = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] mask;
  } ev_t;

  bit         clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_repeat;
  logic       any_press;

  int         cyc;
  int         n_checks;
  int         n_fail;
  ev_t        exp_q[$];
  ev_t        ev;
  logic [3:0] exp_lvl;
  logic [3:0] exp_prs;
  logic [3:0] exp_rel;
  logic [3:0] exp_rep;

  game_button_conditioner #(
    .N_BTN(4), .CNT_W(16), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input int kind, input logic [3:0] mask);
    ev_t e;
    int  i;
    e.cyc  = c;
    e.kind = kind;
    e.mask = mask;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, e);
  endtask

  // Raw change first sampled at edge e_on, held for hold cycles:
  // press at e_on+5, repeats from press+8 every 3, release at e_on+hold+5 (release beats a repeat).
  task automatic sched(input logic [3:0] mask, input int e_on, input int hold);
    int p;
    int r;
    p = e_on + 5;
    r = e_on + hold + 5;
    push(p, K_PRESS, mask);
    for (int t = p + 8; t < r; t += 3) push(t, K_REP, mask);
    push(r, K_REL, mask);
  endtask

  task automatic press_hold(input logic [3:0] mask, input int hold);
    @(negedge clk);
    btn_raw = btn_raw | mask;
    sched(mask, cyc + 1, hold);
    repeat (hold) @(negedge clk);
    btn_raw = btn_raw & ~mask;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: outputs registered at edge cyc are compared at the following negedge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_prs = '0;
      exp_rel = '0;
      exp_rep = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev = exp_q.pop_front();
        case (ev.kind)
          K_PRESS: begin exp_prs |= ev.mask; exp_lvl |= ev.mask;  end
          K_REL:   begin exp_rel |= ev.mask; exp_lvl &= ~ev.mask; end
          K_REP:   exp_rep |= ev.mask;
          default: exp_lvl = '0;
        endcase
      end
      check("level",   btn_level,   exp_lvl);
      check("press",   btn_press,   exp_prs);
      check("release", btn_release, exp_rel);
      check("repeat",  btn_repeat,  exp_rep);
      check("any",     any_press,   |(exp_prs | exp_rep));
    end
  end

  initial begin
    int e;
    int p;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    exp_lvl  = '0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    btn_raw  = 4'hF;

    // Reset held with all buttons asserted: outputs must stay clear.
    repeat (5) @(negedge clk);
    rst_n   = 1'b1;
    btn_raw = 4'h0;
    idle(6);

    // Clean press/hold of button 0.
    press_hold(4'b0001, 15);
    idle(12);

    // Bouncing button 1 never settles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_raw[1] = ((i / 2) % 2 == 0);
    end
    @(negedge clk);
    btn_raw[1] = 1'b0;
    idle(12);

    // Long hold of button 2 with a repeat train.
    press_hold(4'b0100, 30);
    idle(12);

    // Simultaneous press; release lands on a repeat expiry edge.
    press_hold(4'b1001, 20);
    idle(12);

    // Release while still in the repeat delay.
    press_hold(4'b0010, 6);
    idle(12);

    // ena dropped mid-delay on button 3, then restored with the button still held.
    @(negedge clk);
    btn_raw[3] = 1'b1;
    e = cyc + 1;
    p = e + 5;
    push(p, K_PRESS, 4'b1000);
    while (cyc < p + 5) @(negedge clk);
    ena = 1'b0;
    push(p + 6, K_CLR, 4'b0000);
    repeat (3) @(negedge clk);
    ena = 1'b1;
    sched(4'b1000, cyc + 1, 12);
    repeat (12) @(negedge clk);
    btn_raw[3] = 1'b0;
    idle(15);

    check("pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
